// File: rtl/gray_merge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gray_merge_pkg
// Description : Shared types and width helpers for the N-channel weighted
//               grey-level merger.
// Revision    : 1.0 - initial release
// ============================================================================
package gray_merge_pkg;

  // Merger control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUM  = 2'd1,
    ST_DIV  = 2'd2,
    ST_OUT  = 2'd3
  } merge_state_e;

  // Full-precision accumulator width: one product plus log2(channels) carry bits
  function automatic int acc_w(input int data_w, input int weight_w, input int num_ch);
    return data_w + weight_w + $clog2(num_ch);
  endfunction

  // Weight-sum width: one weight plus log2(channels) carry bits
  function automatic int ws_w(input int weight_w, input int num_ch);
    return weight_w + $clog2(num_ch);
  endfunction

  // Largest representable pixel value
  function automatic int sat_max(input int data_w);
    return (1 << data_w) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/merger_chan_fifo.sv
`default_nettype none
// ============================================================================
// Module      : merger_chan_fifo
// Description : Per-channel show-ahead alignment FIFO. dout is valid whenever
//               empty is low. A push while full is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module merger_chan_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_push_ok;
  logic               w_pop_ok;

  assign full      = (r_count == c_cnt_w'(FIFO_DEPTH));
  assign empty     = (r_count == '0);
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;
  assign dout      = r_mem[r_rd_ptr];

  // Storage array; contents need no reset because the count gates visibility
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/gray_multi_weighted_merger.sv
`default_nettype none
// ============================================================================
// Module      : gray_multi_weighted_merger
// Description : N-channel weighted grey-level merger. Each channel is aligned
//               by its own FIFO; when all channels hold a pixel one pixel is
//               popped from each and the weighted average is produced either
//               by an exact restoring divide or a saturating shift.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_multi_weighted_merger
  import gray_merge_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 8,
  parameter int WEIGHT_W   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          in_valid,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  output logic [NUM_CH-1:0]          in_ready,
  input  logic [NUM_CH*WEIGHT_W-1:0] weights,
  input  logic                       mode,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int c_ch_w   = $clog2(NUM_CH);
  localparam int c_acc_w  = acc_w(DATA_W, WEIGHT_W, NUM_CH);
  localparam int c_ws_w   = ws_w(WEIGHT_W, NUM_CH);
  localparam int c_prod_w = DATA_W + WEIGHT_W;
  localparam int c_sh_w   = c_acc_w - WEIGHT_W;
  localparam int c_cnt_w  = $clog2(DATA_W + 1);
  localparam logic [DATA_W-1:0] c_sat_max = DATA_W'(sat_max(DATA_W));

  // Channel FIFO interface
  logic [NUM_CH-1:0]        w_push;
  logic [NUM_CH-1:0]        w_full;
  logic [NUM_CH-1:0]        w_empty;
  logic [NUM_CH*DATA_W-1:0] w_dout;
  logic                     w_pop;

  // Datapath
  logic [c_acc_w-1:0]  w_acc;
  logic [c_ws_w-1:0]   w_wsum;
  logic [c_sh_w-1:0]   w_shift;
  logic [DATA_W-1:0]   w_shift_sat;
  logic [c_ws_w:0]     w_rem_sh;
  logic [c_ws_w-1:0]   w_rem_sub;
  logic                w_q_bit;
  logic [c_ws_w-1:0]   w_rem_nxt;
  logic [DATA_W-1:0]   w_quot_nxt;

  // Registered state
  merge_state_e        r_state;
  logic [c_acc_w-1:0]  r_acc;
  logic [c_ws_w-1:0]   r_wsum;
  logic                r_mode;
  logic [c_ws_w-1:0]   r_rem;
  logic [DATA_W-1:0]   r_quot;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [DATA_W-1:0]   r_result;

  assign w_push   = in_valid & ~w_full;
  assign in_ready = ~w_full;
  assign w_pop    = (r_state == ST_IDLE) && (w_empty == '0);

  genvar gc;
  generate
    for (gc = 0; gc < NUM_CH; gc++) begin : g_chan
      merger_chan_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push[gc]),
        .pop   (w_pop),
        .din   (in_data[gc*DATA_W +: DATA_W]),
        .dout  (w_dout[gc*DATA_W +: DATA_W]),
        .full  (w_full[gc]),
        .empty (w_empty[gc])
      );
    end
  endgenerate

  // Full-precision weighted sum and weight sum of the FIFO heads
  always_comb begin
    w_acc  = '0;
    w_wsum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_acc  = w_acc + {{c_ch_w{1'b0}},
                        ({{WEIGHT_W{1'b0}}, w_dout[c*DATA_W +: DATA_W]} *
                         {{DATA_W{1'b0}}, weights[c*WEIGHT_W +: WEIGHT_W]})};
      w_wsum = w_wsum + {{c_ch_w{1'b0}}, weights[c*WEIGHT_W +: WEIGHT_W]};
    end
  end

  // Shift path: drop WEIGHT_W fraction bits and clamp to the pixel range
  always_comb begin
    w_shift     = r_acc[c_acc_w-1:WEIGHT_W];
    w_shift_sat = (|w_shift[c_sh_w-1:DATA_W]) ? c_sat_max : w_shift[DATA_W-1:0];
  end

  // One restoring-divide step. The remainder stays below wsum, so it fits
  // c_ws_w bits; the MSB of r_quot is the next dividend bit to bring down.
  always_comb begin
    w_rem_sh   = {r_rem, r_quot[DATA_W-1]};
    w_rem_sub  = w_rem_sh[c_ws_w-1:0] - r_wsum;
    w_q_bit    = (w_rem_sh >= {1'b0, r_wsum});
    w_rem_nxt  = w_q_bit ? w_rem_sub : w_rem_sh[c_ws_w-1:0];
    w_quot_nxt = {r_quot[DATA_W-2:0], w_q_bit};
  end

  // Control FSM with inline divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_wsum   <= '0;
      r_mode   <= 1'b0;
      r_rem    <= '0;
      r_quot   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_acc   <= w_acc;
            r_wsum  <= w_wsum;
            r_mode  <= mode;
            r_state <= ST_SUM;
          end
        end
        ST_SUM: begin
          if (r_mode) begin
            r_result <= w_shift_sat;
            r_state  <= ST_OUT;
          end else if (r_wsum == '0) begin
            r_result <= '0;
            r_state  <= ST_OUT;
          end else begin
            // Quotient fits DATA_W bits, so the top bits already lie below wsum
            r_rem   <= r_acc[c_acc_w-1:DATA_W];
            r_quot  <= r_acc[DATA_W-1:0];
            r_cnt   <= c_cnt_w'(DATA_W);
            r_state <= ST_DIV;
          end
        end
        ST_DIV: begin
          r_rem  <= w_rem_nxt;
          r_quot <= w_quot_nxt;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == c_cnt_w'(1)) begin
            r_result <= w_quot_nxt;
            r_state  <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = (r_state == ST_OUT);
  assign out_data  = r_result;

endmodule
`default_nettype wire

// File: doc/gray_multi_weighted_merger.md
# gray_multi_weighted_merger

Parametrised N-channel weighted grey-level merger that blends several independently timed pixel streams into one stream. Each channel has its own small alignment FIFO, so channel streams may arrive skewed. When every channel holds a pixel, one pixel is popped from each channel and the weighted average is produced. The average uses either an exact iterative divide by the weight sum or a fixed-point shift with saturation. It sits in the grey-image pipeline after per-source conversion and before PGM write-out or display, and supersedes the fixed two-input merger.

## Interface
- NUM_CH, 2: number of input channels, 2..8.
- DATA_W, 8: pixel width.
- WEIGHT_W, 8: weight width per channel.
- FIFO_DEPTH, 4: per-channel FIFO depth. Must be a power of two and at least 2.

- clk  in  1  system clock; all logic is synchronous to its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  NUM_CH  per-channel pixel valid.
- in_data  in  NUM_CH*DATA_W  packed pixels; channel c occupies bits [c*DATA_W +: DATA_W].
- in_ready  out  NUM_CH  per-channel accept; equals !full[c].
- weights  in  NUM_CH*WEIGHT_W  packed unsigned weights, same packing as in_data.
- mode  in  1  0 = divide by the weight sum; 1 = shift right by WEIGHT_W with saturation.
- out_data  out  DATA_W  merged pixel.
- out_valid  out  1  merged pixel valid.
- out_ready  in  1  downstream accept.

## Operation
- Push into channel c on a cycle with in_valid[c] && in_ready[c]. A push is refused when the FIFO is full, even if a pop happens in the same cycle. A push and a pop on a non-full FIFO in the same cycle are both legal.
- Width rules:
  - CH_W = clog2(NUM_CH).
  - ACC_W = DATA_W + WEIGHT_W + CH_W.
  - WS_W = WEIGHT_W + CH_W.
  - acc = Σ data[c]*weights[c], computed at full precision with no truncation.
  - wsum = Σ weights[c].
- FSM states are IDLE, SUM, DIV, OUT.
- IDLE:
  - If all FIFOs are non-empty, pop one entry from every channel in the same cycle.
  - Register acc and wsum, and sample mode. Go to SUM.
  - Weights and mode are sampled only at the pop; later changes do not affect a pixel already in flight.
- SUM:
  - If mode = 1: result = acc >> WEIGHT_W, saturated to 2^DATA_W−1. Go to OUT.
  - If mode = 0 and wsum = 0: result = 0. Go to OUT.
  - If mode = 0 and wsum ≠ 0: load a restoring divider. Go to DIV.
- DIV:
  - Produces one quotient bit per cycle, for exactly DATA_W cycles, then go to OUT.
  - The quotient is truncated (floor). It always fits DATA_W because acc < 2^DATA_W·wsum.
- OUT:
  - out_valid = 1 and out_data = result.
  - out_data and out_valid are held stable while out_ready = 0.
  - On out_valid && out_ready, go to IDLE.
- Outputs are produced strictly in input order. There is no reordering and no dropping.

## Timing
- Reset values:
  - out_valid = 0, out_data = 0.
  - All FIFOs empty, so in_ready = all 1s.
  - FSM in IDLE; acc, wsum and divider registers cleared.
- Reset asserted mid-operation (any state): all FIFOs are flushed, the in-flight pixel is discarded, and the outputs return to their reset values immediately.
- Latency from the pop cycle T:
  - out_valid is first high in cycle T+2 for mode 1 or for wsum = 0.
  - out_valid is first high in cycle T+2+DATA_W for mode 0 with wsum ≠ 0.
- Throughput: at most one pixel per 3 cycles (shift mode) or per 3+DATA_W cycles (divide mode). The FSM does not pop again until the OUT handshake completes.
- in_ready is driven combinationally from the FIFO count; it does not depend on in_valid.

## Structure
- Package gray_merge_pkg holds:
  - the FSM state enum;
  - the functions acc_w(), ws_w() and sat_max().
- Sub-module merger_chan_fifo, parameters DATA_W and FIFO_DEPTH:
  - ports: push, pop, din, dout, full, empty;
  - data is valid on dout whenever empty = 0 (show-ahead);
  - instantiated NUM_CH times via generate.
- The divider stays inline in the FSM.

## Test plan
- Divide mode, NUM_CH=2, (g1,g2) = (255,64), wsum = 256, each case checked in both mode 0 and mode 1:
  - weights (128,128) -> 159 in both modes;
  - weights (200,56) -> 213 in both modes;
  - weights (255,1) -> 254 in both modes;
  - weights (1,255) -> 64 in both modes.
- Non-power-of-two weight sum, pixels (255,64), weights (3,1):
  - mode 0 -> 207, with out_valid first high exactly DATA_W+2 cycles after the pop;
  - mode 1 -> 3.
- Saturation and zero weights:
  - mode 1, pixels (255,255), weights (255,255) -> 255 (saturated from 508);
  - mode 0, weights (0,0) -> 0, with the latency of the shift path.
- Skew:
  - Push 3 pixels 10,20,30 on ch0, then wait 20 cycles, then push 3 pixels on ch1.
  - Required: no out_valid before the first ch1 push.
  - Then exactly 3 outputs, in order, each matching its channel pair.
- Backpressure:
  - Hold out_ready = 0 and stream on both channels.
  - Required: in_ready[c] drops after FIFO_DEPTH accepted pushes, plus the one pixel held in the FSM.
  - out_data stays stable while stalled; no data is lost after out_ready is released.
- Reset during DIV:
  - Assert rst_n = 0 midway through DIV.
  - Required: out_valid = 0 immediately and in_ready = all 1s.
  - The next pixel pair after reset produces a correct result with no residue from the discarded pixel.
